// File: rtl/genius_pkg.sv
// Shared definitions for the button front-end, sequence memory and checker.
// Colour codes and the press-arbitration state encoding live here.
package genius_pkg;

   localparam int NUM_BTNS = 3;

   localparam logic [1:0] BTN_CODE_0 = 2'd0;
   localparam logic [1:0] BTN_CODE_1 = 2'd1;
   localparam logic [1:0] BTN_CODE_2 = 2'd2;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } btn_state_e;

   // Caller guarantees i_oh is one-hot.
   function automatic logic [1:0] btn_code(
      input logic [NUM_BTNS-1:0] i_oh
   );
      logic [1:0] w_code;
      w_code = BTN_CODE_0;
      unique case (1'b1)
         i_oh[0]: w_code = BTN_CODE_0;
         i_oh[1]: w_code = BTN_CODE_1;
         i_oh[2]: w_code = BTN_CODE_2;
         default: w_code = BTN_CODE_0;
      endcase
      return w_code;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchronizer, polarity fix and
// saturating-free debounce counter producing an active-high stable level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_stable
);

   localparam logic             REL  = ACTIVE_LOW;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_lvl;

   assign w_lvl    = r_sync2 ^ REL;
   assign o_stable = r_stable;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1  <= REL;
         r_sync2  <= REL;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (w_lvl == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_stable <= w_lvl;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_input_conditioner.sv
// Debounces the three player buttons and turns each physical press into
// one registered press event, rejecting chords until full release.
module btn_input_conditioner
   import genius_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_raw,
   output logic                press_valid,
   output logic [1:0]          press_code,
   output logic [NUM_BTNS-1:0] press_onehot,
   output logic                chord_err,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic                busy
);

   logic [NUM_BTNS-1:0] w_stable;

   btn_state_e          r_state;
   logic                r_valid;
   logic [1:0]          r_code;
   logic [NUM_BTNS-1:0] r_onehot;
   logic                r_chord;
   logic [NUM_BTNS-1:0] r_level;
   logic                r_busy;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW),
         .CNT_W          (CNT_W)
      ) u_db (
         .i_clk   (clock),
         .i_rst   (reset),
         .i_raw   (btn_raw[g]),
         .o_stable(w_stable[g])
      );
   end

   // IDLE is only entered with all levels low, so any nonzero
   // level seen in IDLE is a rise in that cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_valid  <= 1'b0;
         r_code   <= BTN_CODE_0;
         r_onehot <= '0;
         r_chord  <= 1'b0;
         r_level  <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_valid  <= 1'b0;
         r_code   <= BTN_CODE_0;
         r_onehot <= '0;
         r_chord  <= 1'b0;
         r_level  <= w_stable;
         unique case (r_state)
            IDLE: begin
               if (w_stable != '0) begin
                  if ($onehot(w_stable)) begin
                     r_valid  <= 1'b1;
                     r_code   <= btn_code(w_stable);
                     r_onehot <= w_stable;
                  end else begin
                     r_chord <= 1'b1;
                  end
                  r_state <= HELD;
                  r_busy  <= 1'b1;
               end
            end
            HELD: begin
               if (w_stable == '0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign press_valid  = r_valid;
   assign press_code   = r_code;
   assign press_onehot = r_onehot;
   assign chord_err    = r_chord;
   assign btn_level    = r_level;
   assign busy         = r_busy;

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Bench for btn_input_conditioner: window-based reference model feeds an
// event queue; a negedge monitor pops and compares DUT events.
module tb_btn_input_conditioner;

   localparam int DEB = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] btn_raw = 3'b111;
   logic       press_valid;
   logic [1:0] press_code;
   logic [2:0] press_onehot;
   logic       chord_err;
   logic [2:0] btn_level;
   logic       busy;

   always #5 clock = ~clock;

   btn_input_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .press_valid (press_valid),
      .press_code  (press_code),
      .press_onehot(press_onehot),
      .chord_err   (chord_err),
      .btn_level   (btn_level),
      .busy        (busy)
   );

   typedef struct {
      int         kind;
      logic [1:0] code;
      logic [2:0] oh;
      int         cyc;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;

   // pressed-level history: hist[k] = sample taken k+1 edges ago
   logic [2:0] hist [0:DEB];
   logic [2:0] m_stable = '0;
   logic [2:0] m_level = '0;
   bit         m_held = 0;
   bit         m_busy = 0;
   bit         m_flip;
   ev_t        m_ev;

   int ev_cnt = 0;
   int ev_cyc = 0;
   int ev_code = 0;
   int ev_kind = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Stable level flips once DEB consecutive synchronized samples
   // disagree with it; the FSM reacts to the level from before the edge.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k <= DEB; k++) hist[k] = '0;
         m_stable = '0;
         m_level  = '0;
         m_held   = 0;
         m_busy   = 0;
      end else begin
         cyc++;
         m_level = m_stable;
         if (!m_held && m_stable != 0) begin
            m_ev.cyc = cyc;
            if ($countones(m_stable) == 1) begin
               m_ev.kind = 0;
               m_ev.oh   = m_stable;
               m_ev.code = 2'd0;
               for (int b = 0; b < 3; b++)
                  if (m_stable[b]) m_ev.code = 2'(b);
            end else begin
               m_ev.kind = 1;
               m_ev.oh   = '0;
               m_ev.code = 2'd0;
            end
            exp_q.push_back(m_ev);
            m_held = 1;
         end else if (m_held && m_stable == 0) begin
            m_held = 0;
         end
         m_busy = m_held;
         for (int b = 0; b < 3; b++) begin
            m_flip = 1;
            for (int k = 1; k <= DEB; k++)
               if (hist[k][b] == m_stable[b]) m_flip = 0;
            if (m_flip) m_stable[b] = ~m_stable[b];
         end
         for (int k = DEB; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = ~btn_raw;
      end
   end

   ev_t mon_ev;

   always @(negedge clock) begin
      if (reset) begin
         chk("reset_outputs",
             {press_valid, chord_err, busy, btn_level,
              press_code, press_onehot}, 0);
      end else begin
         chk("btn_level", btn_level, m_level);
         chk("busy", busy, m_busy);
         chk("valid_chord_excl", press_valid & chord_err, 0);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none expected kind %0d code %0d at cycle %0d",
                     mon_ev.kind, mon_ev.code, mon_ev.cyc);
         end
         if (press_valid || chord_err) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got valid %0b chord %0b code %0d expected none (cycle %0d)",
                        press_valid, chord_err, press_code, cyc);
            end else begin
               mon_ev = exp_q.pop_front();
               chk("ev_cycle", cyc, mon_ev.cyc);
               chk("ev_kind", chord_err, mon_ev.kind);
               chk("ev_code", press_code, mon_ev.code);
               chk("ev_onehot", press_onehot, mon_ev.oh);
            end
            ev_cnt++;
            ev_cyc  = cyc;
            ev_code = press_code;
            ev_kind = chord_err;
         end else begin
            chk("idle_code", {press_code, press_onehot}, 0);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   int t0, t1, n0, n1;

   initial begin
      step(3);
      chk("reset_state",
          {press_valid, chord_err, busy, btn_level,
           press_code, press_onehot}, 0);
      reset = 1'b0;
      step(10);

      // clean press of button 0
      t0 = cyc; n0 = ev_cnt;
      btn_raw = 3'b110;
      step(20);
      chk("clean_count", ev_cnt - n0, 1);
      chk("clean_latency", ev_cyc - t0, 7);
      chk("clean_code", ev_code, 0);
      chk("clean_busy", busy, 1);
      t1 = cyc;
      btn_raw = 3'b111;
      step(6);
      chk("busy_before_release", busy, 1);
      step(1);
      chk("busy_after_release", busy, 0);
      step(10);

      // bouncing button 1
      n0 = ev_cnt;
      repeat (10) begin
         btn_raw = 3'b101; step(3);
         btn_raw = 3'b111; step(1);
      end
      chk("bounce_no_event", ev_cnt - n0, 0);
      t0 = cyc;
      btn_raw = 3'b101;
      step(12);
      chk("bounce_count", ev_cnt - n0, 1);
      chk("bounce_latency", ev_cyc - t0, 7);
      chk("bounce_code", ev_code, 1);
      btn_raw = 3'b111;
      step(12);

      // chord of buttons 0 and 2
      t0 = cyc; n0 = ev_cnt;
      btn_raw = 3'b010;
      step(12);
      chk("chord_count", ev_cnt - n0, 1);
      chk("chord_kind", ev_kind, 1);
      chk("chord_latency", ev_cyc - t0, 7);
      btn_raw = 3'b011;
      step(12);
      chk("chord_partial_busy", busy, 1);
      btn_raw = 3'b111;
      step(12);
      chk("chord_idle", busy, 0);

      // press while another is held
      n0 = ev_cnt;
      btn_raw = 3'b011;
      step(12);
      chk("held_first_count", ev_cnt - n0, 1);
      chk("held_first_code", ev_code, 2);
      n1 = ev_cnt;
      btn_raw = 3'b010;
      step(12);
      chk("held_second_ignored", ev_cnt - n1, 0);
      btn_raw = 3'b111;
      step(12);
      btn_raw = 3'b110;
      step(12);
      chk("held_after_count", ev_cnt - n1, 1);
      chk("held_after_code", ev_code, 0);
      chk("held_after_kind", ev_kind, 0);
      btn_raw = 3'b111;
      step(12);

      // reset in the middle of a debounce
      n0 = ev_cnt;
      btn_raw = 3'b101;
      step(2);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_outputs",
          {press_valid, chord_err, busy, btn_level,
           press_code, press_onehot}, 0);
      step(3);
      reset = 1'b0;
      t0 = cyc;
      step(12);
      chk("reset_count", ev_cnt - n0, 1);
      chk("reset_latency", ev_cyc - t0, 7);
      chk("reset_code", ev_code, 1);
      btn_raw = 3'b111;
      step(12);

      // back-to-back presses 2, 1, 0
      for (int c = 2; c >= 0; c--) begin
         n0 = ev_cnt;
         btn_raw = ~(3'b001 << c);
         step(12);
         chk("b2b_count", ev_cnt - n0, 1);
         chk("b2b_code", ev_code, c);
         chk("b2b_kind", ev_kind, 0);
         btn_raw = 3'b111;
         step(12);
      end

      // random stimulus against the model
      repeat (400) begin
         btn_raw = 3'($urandom);
         step($urandom_range(1, 10));
         if ($urandom_range(0, 39) == 0) begin
            #2 reset = 1'b1;
            step($urandom_range(1, 3));
            reset = 1'b0;
         end
      end

      btn_raw = 3'b111;
      step(15);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
